// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch (IF) and load/store (DM).
// One access in flight at a time; simultaneous requests alternate round-robin.
//
// state  | meaning
// IDLE   | no access in flight, sampling IF_REQ/DM_REQ for a grant
// ACCESS | latched address/data on MEM_*, counting down the read latency
// DONE   | one-cycle ACK to the granted requester, then back to IDLE
module mem_arbiter #(
    parameter int LATENCY = 1,
    parameter int DATA_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_REQ,
    input  logic [DATA_W-1:0] IF_ADDR,
    output logic [DATA_W-1:0] IF_RDATA,
    output logic              IF_ACK,
    input  logic              DM_REQ,
    input  logic              DM_WE,
    input  logic [DATA_W-1:0] DM_ADDR,
    input  logic [DATA_W-1:0] DM_WDATA,
    output logic [DATA_W-1:0] DM_RDATA,
    output logic              DM_ACK,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_RW,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY,
    output logic [1:0]        GRANT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              mem_rw_q, mem_rw_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              last_dm_q, last_dm_d;
    logic              pick_dm;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        mem_rw_d   = 1'b0;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        last_dm_d  = last_dm_q;
        // On a tie DM wins unless DM was the last one served.
        pick_dm    = DM_REQ && (!IF_REQ || !last_dm_q);

        case (state_q)
            IDLE: begin
                if (IF_REQ || DM_REQ) begin
                    grant_d  = pick_dm ? 2'b10 : 2'b01;
                    addr_d   = pick_dm ? DM_ADDR : IF_ADDR;
                    wdata_d  = pick_dm ? DM_WDATA : '0;
                    we_d     = pick_dm && DM_WE;
                    mem_rw_d = pick_dm && DM_WE;
                    cnt_d    = CNT_LOAD;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (grant_q[1]) dm_rdata_d = MEM_RDATA;
                        else            if_rdata_d = MEM_RDATA;
                    end
                    last_dm_d = grant_q[1];
                    if_ack_d  = grant_q[0];
                    dm_ack_d  = grant_q[1];
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            mem_rw_q   <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            last_dm_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            mem_rw_q   <= mem_rw_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            last_dm_q  <= last_dm_d;
        end
    end

    assign IF_RDATA  = if_rdata_q;
    assign IF_ACK    = if_ack_q;
    assign DM_RDATA  = dm_rdata_q;
    assign DM_ACK    = dm_ack_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign MEM_RW    = mem_rw_q;
    assign BUSY      = (state_q != IDLE);
    assign GRANT     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts every output each cycle,
// plus directed sequences with hand-computed values; a second instance exercises LATENCY = 1.
module tb_mem_arbiter;

    localparam int L = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IF_REQ = 1'b0;
    logic [31:0] IF_ADDR = '0;
    logic [31:0] IF_RDATA;
    logic        IF_ACK;
    logic        DM_REQ = 1'b0;
    logic        DM_WE = 1'b0;
    logic [31:0] DM_ADDR = '0;
    logic [31:0] DM_WDATA = '0;
    logic [31:0] DM_RDATA;
    logic        DM_ACK;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_RW;
    logic [31:0] MEM_RDATA = '0;
    logic        BUSY;
    logic [1:0]  GRANT;

    logic        l1_if_req = 1'b0;
    logic [31:0] l1_if_addr = '0;
    logic [31:0] l1_if_rdata;
    logic        l1_if_ack;
    logic        l1_dm_req = 1'b0;
    logic        l1_dm_we = 1'b0;
    logic [31:0] l1_dm_addr = '0;
    logic [31:0] l1_dm_wdata = '0;
    logic [31:0] l1_dm_rdata;
    logic        l1_dm_ack;
    logic [31:0] l1_mem_addr;
    logic [31:0] l1_mem_wdata;
    logic        l1_mem_rw;
    logic [31:0] l1_mem_rdata = 32'hDEADBEEF;
    logic        l1_busy;
    logic [1:0]  l1_grant;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    mem_arbiter #(.LATENCY(L), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_ACK(IF_ACK),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RW(MEM_RW), .MEM_RDATA(MEM_RDATA),
        .BUSY(BUSY), .GRANT(GRANT)
    );

    mem_arbiter #(.LATENCY(1), .DATA_W(32)) u_l1 (
        .CLK(CLK), .RESET(RESET),
        .IF_REQ(l1_if_req), .IF_ADDR(l1_if_addr), .IF_RDATA(l1_if_rdata), .IF_ACK(l1_if_ack),
        .DM_REQ(l1_dm_req), .DM_WE(l1_dm_we), .DM_ADDR(l1_dm_addr), .DM_WDATA(l1_dm_wdata),
        .DM_RDATA(l1_dm_rdata), .DM_ACK(l1_dm_ack),
        .MEM_ADDR(l1_mem_addr), .MEM_WDATA(l1_mem_wdata), .MEM_RW(l1_mem_rw),
        .MEM_RDATA(l1_mem_rdata), .BUSY(l1_busy), .GRANT(l1_grant)
    );

    always #5 CLK = ~CLK;

    function automatic int idx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Environment memory (written by the DUT's MEM_* strobes) and the model's own shadow copy.
    logic [31:0] env_mem [16];
    logic [31:0] shadow  [16];

    // Transaction-level model: age 1..L are access cycles, age L+1 is the ack cycle.
    bit          m_active = 1'b0;
    int          m_age = 0;
    bit          m_owner = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    bit          m_we = 1'b0;
    bit          m_last_dm = 1'b0;
    logic [31:0] m_if_rd = '0;
    logic [31:0] m_dm_rd = '0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_active  = 1'b0;
            m_age     = 0;
            m_last_dm = 1'b0;
            m_if_rd   = '0;
            m_dm_rd   = '0;
        end else if (m_active) begin
            if (m_age == L + 1) begin
                m_active = 1'b0;
            end else begin
                if (m_age == 1 && m_we) shadow[idx(m_addr)] = m_wdata;
                if (m_age == L) begin
                    if (!m_we) begin
                        if (m_owner) m_dm_rd = shadow[idx(m_addr)];
                        else         m_if_rd = shadow[idx(m_addr)];
                    end
                    m_last_dm = m_owner;
                end
                m_age++;
            end
        end else if (IF_REQ || DM_REQ) begin
            m_owner  = (IF_REQ && DM_REQ) ? !m_last_dm : DM_REQ;
            m_addr   = m_owner ? DM_ADDR : IF_ADDR;
            m_wdata  = DM_WDATA;
            m_we     = m_owner && DM_WE;
            m_active = 1'b1;
            m_age    = 1;
        end
    end

    always @(posedge CLK) begin
        if (MEM_RW) env_mem[idx(MEM_ADDR)] <= MEM_WDATA;
    end

    // Read data is only valid in the last access cycle; junk everywhere else.
    always @(posedge CLK) begin
        #1;
        if (m_active && m_age == L) MEM_RDATA = env_mem[idx(MEM_ADDR)];
        else                         MEM_RDATA = $urandom;
    end

    logic [1:0] exp_grant;
    always @(negedge CLK) begin
        if (cmp_en) begin
            exp_grant = m_active ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("grant", 32'(GRANT), 32'(exp_grant));
            chk("busy", 32'(BUSY), 32'(m_active));
            chk("if_ack", 32'(IF_ACK), 32'(m_active && m_age == L + 1 && !m_owner));
            chk("dm_ack", 32'(DM_ACK), 32'(m_active && m_age == L + 1 && m_owner));
            chk("mem_rw", 32'(MEM_RW), 32'(m_active && m_age == 1 && m_we));
            chk("if_rdata", IF_RDATA, m_if_rd);
            chk("dm_rdata", DM_RDATA, m_dm_rd);
            if (m_active) chk("mem_addr", MEM_ADDR, m_addr);
            if (m_active && m_we) chk("mem_wdata", MEM_WDATA, m_wdata);
        end
    end

    task automatic drive_if();
        if (m_active && m_age == L + 1 && !m_owner) begin
            if ($urandom_range(0, 3) == 0) begin
                IF_ADDR = $urandom;
                IF_REQ  = 1'b1;
            end else begin
                IF_REQ = 1'b0;
            end
        end else if (m_active && !m_owner) begin
            IF_ADDR = $urandom;
            if (IF_REQ && $urandom_range(0, 7) == 0) IF_REQ = 1'b0;
        end else if (!IF_REQ && $urandom_range(0, 1) == 0) begin
            IF_ADDR = $urandom;
            IF_REQ  = 1'b1;
        end
    endtask

    task automatic drive_dm();
        if (m_active && m_age == L + 1 && m_owner) begin
            if ($urandom_range(0, 3) == 0) begin
                DM_ADDR  = $urandom;
                DM_WDATA = $urandom;
                DM_WE    = $urandom_range(0, 1) == 1;
                DM_REQ   = 1'b1;
            end else begin
                DM_REQ = 1'b0;
            end
        end else if (m_active && m_owner) begin
            DM_ADDR  = $urandom;
            DM_WDATA = $urandom;
            DM_WE    = $urandom_range(0, 1) == 1;
            if (DM_REQ && $urandom_range(0, 7) == 0) DM_REQ = 1'b0;
        end else if (!DM_REQ && $urandom_range(0, 1) == 0) begin
            DM_ADDR  = $urandom;
            DM_WDATA = $urandom;
            DM_WE    = $urandom_range(0, 1) == 1;
            DM_REQ   = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = 32'hA000_0000 + 32'(i) * 32'h11;
            shadow[i]  = 32'hA000_0000 + 32'(i) * 32'h11;
        end
        steps(2);
        RESET = 1'b0;
        cmp_en = 1'b1;

        // Idle after reset: everything stays quiet.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_ctl", {27'd0, BUSY, GRANT, IF_ACK, DM_ACK}, 32'd0);
            chk("idle_addr", MEM_ADDR, 32'd0);
        end
        chk("idle_rd", IF_RDATA | DM_RDATA, 32'd0);

        // LATENCY = 1 fetch.
        l1_if_addr = 32'h10;
        l1_if_req  = 1'b1;
        step();
        chk("l1_addr_c1", l1_mem_addr, 32'h10);
        chk("l1_rw_c1", 32'(l1_mem_rw), 32'd0);
        chk("l1_busy_c1", 32'(l1_busy), 32'd1);
        step();
        chk("l1_ack_c2", 32'(l1_if_ack), 32'd1);
        chk("l1_rdata_c2", l1_if_rdata, 32'hDEADBEEF);
        chk("l1_rw_c2", 32'(l1_mem_rw), 32'd0);
        l1_if_req = 1'b0;
        step();
        chk("l1_ack_c3", 32'(l1_if_ack), 32'd0);
        chk("l1_busy_c3", 32'(l1_busy), 32'd0);

        // Tie: DM first, then IF, then DM wins the next tie.
        IF_ADDR = 32'h8;
        IF_REQ  = 1'b1;
        DM_ADDR = 32'h4;
        DM_WE   = 1'b0;
        DM_REQ  = 1'b1;
        step();
        chk("tie1_grant", 32'(GRANT), 32'd2);
        steps(3);
        chk("tie1_dm_ack", 32'(DM_ACK), 32'd1);
        chk("tie1_dm_rd", DM_RDATA, 32'hA000_0011);
        DM_REQ = 1'b0;
        step();
        chk("tie1_idle", {30'd0, GRANT}, 32'd0);
        step();
        chk("tie1_if_grant", 32'(GRANT), 32'd1);
        steps(3);
        chk("tie1_if_ack", 32'(IF_ACK), 32'd1);
        chk("tie1_if_rd", IF_RDATA, 32'hA000_0022);
        DM_REQ = 1'b1;
        steps(2);
        chk("tie2_grant", 32'(GRANT), 32'd2);
        steps(3);
        chk("tie2_dm_ack", 32'(DM_ACK), 32'd1);
        DM_REQ = 1'b0;
        steps(2);
        chk("tie2_if_grant", 32'(GRANT), 32'd1);
        steps(3);
        chk("tie2_if_ack", 32'(IF_ACK), 32'd1);
        IF_REQ = 1'b0;
        step();

        // Store 0x1234 to 0x40; later address/data changes are ignored.
        DM_ADDR  = 32'h40;
        DM_WDATA = 32'h1234;
        DM_WE    = 1'b1;
        DM_REQ   = 1'b1;
        step();
        chk("st_rw_c1", 32'(MEM_RW), 32'd1);
        chk("st_addr_c1", MEM_ADDR, 32'h40);
        chk("st_wdata_c1", MEM_WDATA, 32'h1234);
        DM_ADDR  = 32'hFFFF_FFFC;
        DM_WDATA = 32'h5555_5555;
        DM_WE    = 1'b0;
        step();
        chk("st_rw_c2", 32'(MEM_RW), 32'd0);
        step();
        chk("st_rw_c3", 32'(MEM_RW), 32'd0);
        chk("st_addr_c3", MEM_ADDR, 32'h40);
        chk("st_wdata_c3", MEM_WDATA, 32'h1234);
        step();
        chk("st_ack_c4", 32'(DM_ACK), 32'd1);
        chk("st_rd_keep", DM_RDATA, 32'hA000_0011);
        DM_REQ = 1'b0;
        step();

        // Load back from 0x40 with DM_REQ dropped mid-access.
        DM_ADDR = 32'h40;
        DM_WE   = 1'b0;
        DM_REQ  = 1'b1;
        steps(2);
        DM_REQ = 1'b0;
        steps(2);
        chk("drop_ack", 32'(DM_ACK), 32'd1);
        chk("drop_rd", DM_RDATA, 32'h1234);
        step();

        // Reset in the second access cycle of a load.
        DM_ADDR = 32'h4;
        DM_REQ  = 1'b1;
        steps(2);
        RESET  = 1'b1;
        DM_REQ = 1'b0;
        #1;
        chk("rst_ctl", {27'd0, BUSY, GRANT, DM_ACK, MEM_RW}, 32'd0);
        chk("rst_rd", IF_RDATA | DM_RDATA, 32'd0);
        chk("rst_addr", MEM_ADDR | MEM_WDATA, 32'd0);
        step();
        RESET = 1'b0;
        step();
        chk("rst_no_ack", 32'(DM_ACK), 32'd0);
        IF_ADDR = 32'hC;
        IF_REQ  = 1'b1;
        steps(4);
        chk("rst_fresh_ack", 32'(IF_ACK), 32'd1);
        chk("rst_fresh_rd", IF_RDATA, 32'hA000_0033);
        IF_REQ = 1'b0;
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                RESET  = 1'b1;
                IF_REQ = 1'b0;
                DM_REQ = 1'b0;
                step();
                RESET = 1'b0;
            end
            drive_if();
            drive_dm();
            step();
        end
        IF_REQ = 1'b0;
        DM_REQ = 1'b0;
        steps(L + 4);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
